// File: rtl/launch_pkg.sv
// launch_pkg: shared definitions for the launch sequencer.
//   - STATE_W   : width of the FSM state code presented on state_o
//   - state_t   : FSM state encodings (IDLE=0 .. ABORT=4; 5..7 illegal)
//   - presc_width(): prescaler counter width for a CLK_HZ/TICK_HZ divider
package launch_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_COUNT  = 3'd2,
        ST_IGNITE = 3'd3,
        ST_ABORT  = 3'd4
    } state_t;

    // Width of a counter that must reach DIV-1, where DIV = clk_hz/tick_hz.
    // Never below 1 so the smallest legal divider (2) still gets a bit.
    function automatic int presc_width(input int clk_hz, input int tick_hz);
        int div_v;
        div_v = clk_hz / tick_hz;
        if (div_v <= 2) begin
            return 1;
        end else begin
            return $clog2(div_v);
        end
    endfunction

endpackage

// File: rtl/launch_sequencer_if.sv
// launch_sequencer_if: front-panel request pulses and sequencer status.
//   master : drives arm/launch/abort pulses, observes status
//   slave  : the sequencer; consumes pulses, drives count_val, state_o,
//            armed, ignite, aborted, done_pulse
interface launch_sequencer_if #(
    parameter int CNT_W = 4
) ();
    import launch_pkg::*;

    logic               arm_pulse;
    logic               launch_pulse;
    logic               abort_pulse;
    logic [CNT_W-1:0]   count_val;
    logic [STATE_W-1:0] state_o;
    logic               armed;
    logic               ignite;
    logic               aborted;
    logic               done_pulse;

    modport master (
        output arm_pulse, launch_pulse, abort_pulse,
        input  count_val, state_o, armed, ignite, aborted, done_pulse
    );

    modport slave (
        input  arm_pulse, launch_pulse, abort_pulse,
        output count_val, state_o, armed, ignite, aborted, done_pulse
    );

endinterface

// File: rtl/launch_sequencer_tick_gen.sv
// tick_gen: free-running divide-by-DIV prescaler.
//   clk  : clock
//   rst  : synchronous active-high reset (counter -> 0)
//   clr  : synchronous clear (counter -> 0), restarts the tick period
//   tick : high for one cycle while the counter sits at DIV-1
// After a clear or reset the first tick appears DIV cycles later.
module tick_gen #(
    parameter int DIV = 2,
    parameter int W   = (DIV <= 2) ? 1 : $clog2(DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    logic [W-1:0] presc_r;

    // Terminal-count decode of the prescaler register.
    assign tick = (presc_r == W'(DIV - 1));

    // Prescaler: counts 0..DIV-1 and wraps; reset/clear restart the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
        end else if (clr || tick) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + W'(1);
        end
    end

endmodule

// File: rtl/launch_sequencer.sv
// launch_sequencer: launch-control FSM (IDLE, ARMED, COUNT, IGNITE, ABORT).
//   clk, rst : clock and synchronous active-high reset
//   bus      : launch_sequencer_if.slave -- arm/launch/abort pulses in;
//              count_val, state_o, armed, ignite, aborted, done_pulse out
// All outputs are registered. Same-cycle priority is abort > launch > arm.
// Build option ARM_TIMEOUT_EN: ARMED auto-disarms after ARM_TIMEOUT_TICKS
// ticks without launch/abort; when undefined ARMED waits indefinitely.
module launch_sequencer
    import launch_pkg::*;
#(
    parameter int CLK_HZ            = 12000000,
    parameter int TICK_HZ           = 1,
    parameter int COUNT_START       = 10,
    parameter int CNT_W             = 4,
    parameter int IGNITE_TICKS      = 3,
    parameter int ARM_TIMEOUT_TICKS = 30
) (
    input  logic                clk,
    input  logic                rst,
    launch_sequencer_if.slave   bus
);

    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int PRESC_W = presc_width(CLK_HZ, TICK_HZ);
    // One phase-tick counter serves both the ignition hold and the arm timeout.
    localparam int TMAX    = (IGNITE_TICKS > ARM_TIMEOUT_TICKS) ? IGNITE_TICKS : ARM_TIMEOUT_TICKS;
    localparam int TCNT_W  = $clog2(TMAX + 1);

    state_t             state_r, state_n;
    logic [CNT_W-1:0]   count_r, count_n;
    logic [TCNT_W-1:0]  tcnt_r;
    logic               armed_r, ignite_r, aborted_r, done_r;
    logic               tick_s;
    logic               trans_s;

    // Any state change restarts both the prescaler and the phase-tick count.
    assign trans_s = (state_n != state_r);

    tick_gen #(
        .DIV (DIV),
        .W   (PRESC_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (trans_s),
        .tick (tick_s)
    );

    // Next-state and next-count decode.
    always_comb begin
        state_n = state_r;
        count_n = count_r;
        case (state_r)
            ST_IDLE: begin
                count_n = CNT_W'(COUNT_START);
                if (bus.arm_pulse) begin
                    state_n = ST_ARMED;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (bus.abort_pulse) begin
                    state_n = ST_IDLE;
                end else if (bus.launch_pulse) begin
                    state_n = ST_COUNT;
                    count_n = CNT_W'(COUNT_START);
`ifdef ARM_TIMEOUT_EN
                end else if (tick_s && (tcnt_r == TCNT_W'(ARM_TIMEOUT_TICKS - 1))) begin
                    state_n = ST_IDLE;
`endif
                end else begin
                    state_n = ST_ARMED;
                end
            end
            ST_COUNT: begin
                if (bus.abort_pulse) begin
                    state_n = ST_ABORT;
                end else if (tick_s) begin
                    if (count_r == CNT_W'(1)) begin
                        count_n = CNT_W'(0);
                        state_n = ST_IGNITE;
                    end else if (count_r != CNT_W'(0)) begin
                        count_n = count_r - CNT_W'(1);
                    end else begin
                        count_n = count_r;
                    end
                end else begin
                    state_n = ST_COUNT;
                end
            end
            ST_IGNITE: begin
                if (tick_s && (tcnt_r == TCNT_W'(IGNITE_TICKS - 1))) begin
                    state_n = ST_IDLE;
                    count_n = CNT_W'(COUNT_START);
                end else begin
                    state_n = ST_IGNITE;
                end
            end
            ST_ABORT: begin
                if (bus.arm_pulse) begin
                    state_n = ST_IDLE;
                    count_n = CNT_W'(COUNT_START);
                end else begin
                    state_n = ST_ABORT;
                end
            end
            default: begin
                state_n = ST_IDLE;
                count_n = CNT_W'(COUNT_START);
            end
        endcase
    end

    // Phase-tick counter: ticks seen since entering the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_r <= '0;
        end else if (trans_s) begin
            tcnt_r <= '0;
        end else if (tick_s) begin
            tcnt_r <= tcnt_r + TCNT_W'(1);
        end else begin
            tcnt_r <= tcnt_r;
        end
    end

    // State, count and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            count_r   <= CNT_W'(COUNT_START);
            armed_r   <= 1'b0;
            ignite_r  <= 1'b0;
            aborted_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            count_r   <= count_n;
            armed_r   <= (state_n == ST_ARMED) || (state_n == ST_COUNT);
            ignite_r  <= (state_n == ST_IGNITE);
            aborted_r <= (state_n == ST_ABORT);
            done_r    <= (state_r == ST_IGNITE) && (state_n == ST_IDLE);
        end
    end

    assign bus.count_val  = count_r;
    assign bus.state_o    = state_r;
    assign bus.armed      = armed_r;
    assign bus.ignite     = ignite_r;
    assign bus.aborted    = aborted_r;
    assign bus.done_pulse = done_r;

endmodule

// File: tb/tb_launch_sequencer.sv
// tb_launch_sequencer: directed self-checking bench for launch_sequencer.
// DIV = 8, COUNT_START = 3, IGNITE_TICKS = 2, ARM_TIMEOUT_TICKS = 2.
// The auto-disarm checks are compiled only when ARM_TIMEOUT_EN is defined.
module tb_launch_sequencer;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    launch_sequencer_if #(.CNT_W(4)) bus_if ();

    launch_sequencer #(
        .CLK_HZ            (8),
        .TICK_HZ           (1),
        .COUNT_START       (3),
        .CNT_W             (4),
        .IGNITE_TICKS      (2),
        .ARM_TIMEOUT_TICKS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; land 1 ns after the last edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a one-cycle request on any combination of the three buttons.
    task automatic pulse(input logic a, input logic l, input logic ab);
        bus_if.arm_pulse    = a;
        bus_if.launch_pulse = l;
        bus_if.abort_pulse  = ab;
        step(1);
        bus_if.arm_pulse    = 1'b0;
        bus_if.launch_pulse = 1'b0;
        bus_if.abort_pulse  = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus_if.arm_pulse    = 1'b0;
        bus_if.launch_pulse = 1'b0;
        bus_if.abort_pulse  = 1'b0;

        // 1. reset state
        step(2);
        rst = 1'b0;
        chk("rst_state", int'(bus_if.state_o), 0);
        chk("rst_count", int'(bus_if.count_val), 3);
        chk("rst_flags", int'({bus_if.armed, bus_if.ignite, bus_if.aborted, bus_if.done_pulse}), 0);

        // 2. full launch: arm, launch, countdown, ignition, done
        pulse(1'b1, 1'b0, 1'b0);
        chk("arm_state", int'(bus_if.state_o), 1);
        chk("arm_armed", int'(bus_if.armed), 1);
        pulse(1'b0, 1'b1, 1'b0);
        chk("launch_state", int'(bus_if.state_o), 2);
        chk("launch_armed", int'(bus_if.armed), 1);
        chk("launch_count", int'(bus_if.count_val), 3);
        step(7);
        chk("cnt_t1p8", int'(bus_if.count_val), 3);
        step(1);
        chk("cnt_t1p9", int'(bus_if.count_val), 2);
        step(8);
        chk("cnt_t1p17", int'(bus_if.count_val), 1);
        step(8);
        chk("cnt_t1p25", int'(bus_if.count_val), 0);
        chk("ign_state", int'(bus_if.state_o), 3);
        chk("ign_on", int'(bus_if.ignite), 1);
        chk("ign_armed", int'(bus_if.armed), 0);
        step(15);
        chk("ign_hold", int'(bus_if.ignite), 1);
        chk("ign_nodone", int'(bus_if.done_pulse), 0);
        step(1);
        chk("done_pulse", int'(bus_if.done_pulse), 1);
        chk("done_ignite", int'(bus_if.ignite), 0);
        chk("done_state", int'(bus_if.state_o), 0);
        chk("done_count", int'(bus_if.count_val), 3);
        step(1);
        chk("done_once", int'(bus_if.done_pulse), 0);

        // 3. abort mid-countdown, then acknowledge
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        step(8);
        chk("ab_pre_count", int'(bus_if.count_val), 2);
        step(3);
        pulse(1'b0, 1'b0, 1'b1);
        chk("ab_state", int'(bus_if.state_o), 4);
        chk("ab_flag", int'(bus_if.aborted), 1);
        chk("ab_count", int'(bus_if.count_val), 2);
        step(20);
        chk("ab_hold_state", int'(bus_if.state_o), 4);
        chk("ab_hold_count", int'(bus_if.count_val), 2);
        chk("ab_no_ignite", int'(bus_if.ignite), 0);
        pulse(1'b0, 1'b1, 1'b1);
        chk("ab_ign_la", int'(bus_if.state_o), 4);
        pulse(1'b1, 1'b0, 1'b0);
        chk("ack_state", int'(bus_if.state_o), 0);
        chk("ack_count", int'(bus_if.count_val), 3);
        chk("ack_aborted", int'(bus_if.aborted), 0);

        // 4. abort on the same edge as the tick that would reach 1
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        step(8);
        chk("race_pre", int'(bus_if.count_val), 2);
        step(7);
        pulse(1'b0, 1'b0, 1'b1);
        chk("race_state", int'(bus_if.state_o), 4);
        chk("race_count", int'(bus_if.count_val), 2);
        pulse(1'b1, 1'b0, 1'b0);
        //    launch + abort together in ARMED: abort wins -> IDLE
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1);
        chk("la_ab_state", int'(bus_if.state_o), 0);
        chk("la_ab_armed", int'(bus_if.armed), 0);

        // 5. ignored inputs, then reset during ignition
        pulse(1'b0, 1'b1, 1'b0);
        chk("idle_launch", int'(bus_if.state_o), 0);
        pulse(1'b0, 1'b0, 1'b1);
        chk("idle_abort", int'(bus_if.state_o), 0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("armed_rearm", int'(bus_if.state_o), 1);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("count_arm", int'(bus_if.state_o), 2);
        chk("count_arm_cnt", int'(bus_if.count_val), 3);
        step(23);
        chk("ign2_state", int'(bus_if.state_o), 3);
        pulse(1'b0, 1'b0, 1'b1);
        chk("ign_abort", int'(bus_if.state_o), 3);
        chk("ign_abort_on", int'(bus_if.ignite), 1);
        pulse(1'b1, 1'b1, 1'b0);
        chk("ign_arm_launch", int'(bus_if.state_o), 3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("ign_rst_ignite", int'(bus_if.ignite), 0);
        chk("ign_rst_state", int'(bus_if.state_o), 0);
        chk("ign_rst_count", int'(bus_if.count_val), 3);

`ifdef ARM_TIMEOUT_EN
        // 6. auto-disarm after two ticks in ARMED, and launch beating it
        pulse(1'b1, 1'b0, 1'b0);
        step(15);
        chk("to_hold", int'(bus_if.state_o), 1);
        step(1);
        chk("to_idle", int'(bus_if.state_o), 0);
        pulse(1'b1, 1'b0, 1'b0);
        step(15);
        pulse(1'b0, 1'b1, 1'b0);
        chk("to_launch", int'(bus_if.state_o), 2);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
`else
        // Without the timeout, ARMED persists well past any tick count.
        pulse(1'b1, 1'b0, 1'b0);
        step(40);
        chk("armed_persist", int'(bus_if.state_o), 1);
        pulse(1'b0, 1'b0, 1'b1);
`endif
        chk("end_state", int'(bus_if.state_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
